// File: rtl/mem_port_b_arbiter_pkg.sv
// Shared definitions for the port-B arbiter: default widths, access opcodes
// and a helper that sizes requester index fields.
package mem_port_b_arbiter_pkg;

    localparam int DEF_N_REQ  = 3;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 16;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Width of a requester index; never zero so single-requester builds still elaborate.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_b_arbiter_if.sv
// Bundle of requester handshakes and RAM port-B signals seen by the arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM side.
interface mem_port_b_arbiter_if
    import mem_port_b_arbiter_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_din;
    logic                    mem_we;
    logic [DATA_W-1:0]       mem_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_dout,
        output gnt, rsp_valid, rsp_data, mem_addr, mem_din, mem_we
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_dout,
        input  gnt, rsp_valid, rsp_data, mem_addr, mem_din, mem_we
    );

endinterface

// File: rtl/mem_port_b_arbiter_rr_picker.sv
// Combinational round-robin picker: searches upward from the requester after
// the last winner, wrapping around, with optional fixed priority for index 0.
module mem_port_b_arbiter_rr_picker
    import mem_port_b_arbiter_pkg::*;
#(
    parameter int  N_REQ = DEF_N_REQ,
    parameter bit  PRIO0 = 1'b0,
    localparam int IDX_W = idxWidth(N_REQ)
) (
    input  logic [N_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_anyValid
);

    logic [IDX_W-1:0] w_cand;

    // First eligible requester after the last winner wins; requester 0 may override.
    always_comb begin
        o_winner   = '0;
        o_anyValid = 1'b0;
        w_cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last) + k) % N_REQ);
            if (!o_anyValid && i_eligible[w_cand]) begin
                o_winner   = w_cand;
                o_anyValid = 1'b1;
            end
        end
        if (PRIO0 && i_eligible[0]) begin
            o_winner   = '0;
            o_anyValid = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_b_arbiter.sv
// Port-B arbiter for the dual-port block RAM: issues one registered access per
// cycle to the round-robin winner and routes read data back two cycles after
// the request via a two-stage tag pipeline.
module mem_port_b_arbiter
    import mem_port_b_arbiter_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter bit PRIO0  = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    mem_port_b_arbiter_if.slave bus
);

    localparam int IDX_W = idxWidth(N_REQ);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] id;
    } tag_t;

    logic [N_REQ-1:0]  r_gnt;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memDin;
    logic              r_memWe;
    logic [IDX_W-1:0]  r_last;
    tag_t              r_tagIssue;
    tag_t              r_tagResp;

    logic [N_REQ-1:0]  w_eligible;
    logic [IDX_W-1:0]  w_winner;
    logic              w_anyValid;
    logic [ADDR_W-1:0] w_selAddr;
    logic [DATA_W-1:0] w_selDin;
    logic              w_selWe;
    logic [N_REQ-1:0]  w_gntNext;
    logic [N_REQ-1:0]  w_rspValid;

    // A requester still holding valid during its grant cycle must not be issued twice.
    assign w_eligible = bus.req_valid & ~r_gnt;

    mem_port_b_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .PRIO0 (PRIO0)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_last     (r_last),
        .o_winner   (w_winner),
        .o_anyValid (w_anyValid)
    );

    // Select the winner's address, data and direction out of the flattened buses.
    always_comb begin
        w_selAddr = '0;
        w_selDin  = '0;
        w_selWe   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == w_winner) begin
                w_selAddr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_selDin  = bus.req_wdata[i*DATA_W +: DATA_W];
                w_selWe   = bus.req_we[i];
            end
        end
    end

    // One-hot decode of the winner for the grant pulse.
    always_comb begin
        w_gntNext           = '0;
        w_gntNext[w_winner] = 1'b1;
    end

    // Issue registers, pointer and tag pipeline; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt      <= '0;
            r_memAddr  <= '0;
            r_memDin   <= '0;
            r_memWe    <= 1'b0;
            r_last     <= IDX_W'(N_REQ - 1);
            r_tagIssue <= '0;
            r_tagResp  <= '0;
        end else begin
            r_tagResp <= r_tagIssue;
            if (w_anyValid) begin
                r_gnt      <= w_gntNext;
                r_last     <= w_winner;
                r_memAddr  <= w_selAddr;
                r_memDin   <= w_selDin;
                r_memWe    <= w_selWe;
                r_tagIssue <= '{valid: (op_e'(w_selWe) == OP_READ), id: w_winner};
            end else begin
                r_gnt      <= '0;
                r_memWe    <= 1'b0;
                r_tagIssue <= '0;
            end
        end
    end

    // Delayed tag lines up with RAM output and steers the response pulse.
    always_comb begin
        w_rspValid = '0;
        if (r_tagResp.valid) begin
            w_rspValid[r_tagResp.id] = 1'b1;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = w_rspValid;
    assign bus.rsp_data  = bus.mem_dout;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_din   = r_memDin;
    assign bus.mem_we    = r_memWe;

endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Self-checking bench for mem_port_b_arbiter: directed scenarios plus a
// randomized requester population checked against a cycle-level reference.
module tb_mem_port_b_arbiter;
    import mem_port_b_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 15;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_b_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) if0 ();
    mem_port_b_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) if1 ();

    mem_port_b_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .PRIO0(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    mem_port_b_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .PRIO0(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    int checks = 0;
    int errors = 0;

    // Power-up contents of the RAM; address 0x0010 holds a recognisable word.
    function automatic logic [DW-1:0] initWord(input logic [AW-1:0] a);
        if (a == 15'h0010) return 16'hBEEF;
        return DW'(a) ^ 16'h5A5A;
    endfunction

    // Synchronous read-first RAM on port B of dut0 (sparse storage).
    logic [DW-1:0] ram0 [int];
    logic [DW-1:0] ram0Rd;
    always @(posedge clk) begin
        ram0Rd = ram0.exists(int'(if0.mem_addr)) ? ram0[int'(if0.mem_addr)] : initWord(if0.mem_addr);
        if (if0.mem_we) ram0[int'(if0.mem_addr)] = if0.mem_din;
        if0.mem_dout <= ram0Rd;
    end

    // dut1's RAM just echoes the address one cycle later.
    always @(posedge clk) if1.mem_dout <= DW'(if1.mem_addr);

    // Reference model state for dut0.
    logic [N-1:0]  mGnt;
    int            mLast;
    logic          mWe;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mDin;
    logic          mTagV;
    int            mTagId;
    logic [DW-1:0] mTagData;
    logic [N-1:0]  mRspValid;
    logic [DW-1:0] mRspData;
    logic [DW-1:0] shadow [int];

    function automatic int pick(input logic [N-1:0] e, input int last);
        for (int k = 1; k <= N; k++) if (e[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Advance the reference by one edge using the currently driven inputs, then clock.
    task automatic applyStimulus();
        logic [N-1:0] elig;
        int w;
        if (reset) begin
            mGnt = '0; mLast = N - 1; mWe = 1'b0; mAddr = '0; mDin = '0;
            mTagV = 1'b0; mRspValid = '0;
        end else begin
            mRspValid = mTagV ? (N'(1) << mTagId) : '0;
            mRspData  = mTagData;
            elig = if0.req_valid & ~mGnt;
            w = pick(elig, mLast);
            if (w >= 0) begin
                mGnt   = N'(1) << w;
                mLast  = w;
                mWe    = if0.req_we[w];
                mAddr  = if0.req_addr[w*AW +: AW];
                mDin   = if0.req_wdata[w*DW +: DW];
                mTagV  = !mWe;
                mTagId = w;
                if (mWe) shadow[int'(mAddr)] = mDin;
                else mTagData = shadow.exists(int'(mAddr)) ? shadow[int'(mAddr)] : initWord(mAddr);
            end else begin
                mGnt = '0; mWe = 1'b0; mTagV = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if0.req_valid[i] = v;
        if0.req_we[i] = we;
        if0.req_addr[i*AW +: AW] = a;
        if0.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) setReq(i, 1'b1, 1'b0, AW'(i * 4), '0);
        repeat (2) begin
            applyStimulus();
            checks++; if (if0.gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_gnt got %b want 000", if0.gnt); end
            checks++; if (if0.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL reset_rsp got %b want 000", if0.rsp_valid); end
            checks++; if (if0.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", if0.mem_we); end
            checks++; if (if0.mem_addr !== 15'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", if0.mem_addr); end
        end
        reset = 1'b0;
        applyStimulus();
        checks++; if (if0.gnt !== 3'b001) begin errors++; $display("[TB] FAIL release_gnt got %b want 001", if0.gnt); end
        if0.req_valid = '0;
        applyStimulus();
        checks++; if (if0.rsp_valid !== 3'b001) begin errors++; $display("[TB] FAIL release_rsp got %b want 001", if0.rsp_valid); end
        repeat (2) applyStimulus();
    endtask

    task automatic test_single_read();
        setReq(1, 1'b1, 1'b0, 15'h0010, '0);
        applyStimulus();
        checks++; if (if0.gnt !== 3'b010) begin errors++; $display("[TB] FAIL sr_gnt got %b want 010", if0.gnt); end
        checks++; if (if0.mem_addr !== 15'h0010) begin errors++; $display("[TB] FAIL sr_addr got %h want 0010", if0.mem_addr); end
        checks++; if (if0.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL sr_we got %b want 0", if0.mem_we); end
        if0.req_valid[1] = 1'b0;
        applyStimulus();
        checks++; if (if0.rsp_valid !== 3'b010) begin errors++; $display("[TB] FAIL sr_rsp got %b want 010", if0.rsp_valid); end
        checks++; if (if0.rsp_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL sr_data got %h want BEEF", if0.rsp_data); end
        applyStimulus();
    endtask

    task automatic test_write_readback();
        setReq(2, 1'b1, 1'b1, 15'h7FFF, 16'h1234);
        applyStimulus();
        checks++; if (if0.gnt !== 3'b100) begin errors++; $display("[TB] FAIL wr_gnt got %b want 100", if0.gnt); end
        checks++; if (if0.mem_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_we got %b want 1", if0.mem_we); end
        checks++; if (if0.mem_addr !== 15'h7FFF || if0.mem_din !== 16'h1234) begin errors++; $display("[TB] FAIL wr_bus got %h/%h want 7fff/1234", if0.mem_addr, if0.mem_din); end
        setReq(2, 1'b1, 1'b0, 15'h7FFF, 16'h0000);
        applyStimulus();
        checks++; if (if0.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL wr_we_pulse got %b want 0", if0.mem_we); end
        checks++; if (if0.gnt !== 3'b000) begin errors++; $display("[TB] FAIL rb_mask got %b want 000", if0.gnt); end
        applyStimulus();
        checks++; if (if0.gnt !== 3'b100) begin errors++; $display("[TB] FAIL rb_gnt got %b want 100", if0.gnt); end
        checks++; if (if0.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL wr_norsp got %b want 000", if0.rsp_valid); end
        if0.req_valid[2] = 1'b0;
        applyStimulus();
        checks++; if (if0.rsp_valid !== 3'b100) begin errors++; $display("[TB] FAIL rb_rsp got %b want 100", if0.rsp_valid); end
        checks++; if (if0.rsp_data !== 16'h1234) begin errors++; $display("[TB] FAIL rb_data got %h want 1234", if0.rsp_data); end
        applyStimulus();
    endtask

    task automatic test_round_robin();
        int cnt [N];
        logic [N-1:0] prevGnt;
        int mx, mn;
        prevGnt = '0;
        for (int i = 0; i < N; i++) begin cnt[i] = 0; setReq(i, 1'b1, 1'b0, AW'(32 + i), '0); end
        for (int c = 0; c < 30; c++) begin
            applyStimulus();
            if (c == 0) begin
                checks++; if (if0.gnt !== 3'b001) begin errors++; $display("[TB] FAIL rr_first got %b want 001", if0.gnt); end
            end
            checks++; if (if0.gnt !== mGnt) begin errors++; $display("[TB] FAIL rr_gnt cycle %0d got %b want %b", c, if0.gnt, mGnt); end
            checks++; if (if0.rsp_valid !== prevGnt) begin errors++; $display("[TB] FAIL rr_rsp cycle %0d got %b want %b", c, if0.rsp_valid, prevGnt); end
            if (mRspValid != '0) begin
                checks++; if (if0.rsp_data !== mRspData) begin errors++; $display("[TB] FAIL rr_data cycle %0d got %h want %h", c, if0.rsp_data, mRspData); end
            end
            for (int i = 0; i < N; i++) cnt[i] += int'(if0.gnt[i] === 1'b1);
            prevGnt = mGnt;
        end
        mx = cnt[0]; mn = cnt[0];
        for (int i = 1; i < N; i++) begin if (cnt[i] > mx) mx = cnt[i]; if (cnt[i] < mn) mn = cnt[i]; end
        checks++; if (mx - mn > 1 || cnt[0] + cnt[1] + cnt[2] != 30) begin errors++; $display("[TB] FAIL rr_balance got %0d/%0d/%0d want 10 each", cnt[0], cnt[1], cnt[2]); end
        if0.req_valid = '0;
        repeat (2) applyStimulus();
    endtask

    task automatic test_random();
        bit active [N];
        for (int i = 0; i < N; i++) active[i] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (mGnt[i]) begin
                    active[i] = 1'b0; if0.req_valid[i] = 1'b0;
                end else if (active[i] && $urandom_range(7) == 0) begin
                    active[i] = 1'b0; if0.req_valid[i] = 1'b0;
                end else if (!active[i] && $urandom_range(1) == 1) begin
                    active[i] = 1'b1;
                    setReq(i, 1'b1, 1'($urandom_range(1)), AW'(15'h0100 + $urandom_range(7)), DW'($urandom));
                end
            end
            applyStimulus();
            checks++; if (if0.gnt !== mGnt) begin errors++; $display("[TB] FAIL rnd_gnt cycle %0d got %b want %b", c, if0.gnt, mGnt); end
            checks++; if (if0.mem_we !== mWe) begin errors++; $display("[TB] FAIL rnd_we cycle %0d got %b want %b", c, if0.mem_we, mWe); end
            checks++; if (if0.mem_addr !== mAddr || if0.mem_din !== mDin) begin errors++; $display("[TB] FAIL rnd_bus cycle %0d got %h/%h want %h/%h", c, if0.mem_addr, if0.mem_din, mAddr, mDin); end
            checks++; if (if0.rsp_valid !== mRspValid) begin errors++; $display("[TB] FAIL rnd_rsp cycle %0d got %b want %b", c, if0.rsp_valid, mRspValid); end
            if (mRspValid != '0) begin
                checks++; if (if0.rsp_data !== mRspData) begin errors++; $display("[TB] FAIL rnd_data cycle %0d got %h want %h", c, if0.rsp_data, mRspData); end
            end
        end
        if0.req_valid = '0;
        repeat (3) applyStimulus();
    endtask

    task automatic test_prio0();
        logic [N-1:0] want, prevWant;
        int zeroCnt;
        zeroCnt = 0;
        prevWant = '0;
        if1.req_valid = 3'b101;
        for (int c = 0; c < 20; c++) begin
            applyStimulus();
            want = (c % 2 == 0) ? 3'b001 : 3'b100;
            checks++; if (if1.gnt !== want) begin errors++; $display("[TB] FAIL prio_gnt cycle %0d got %b want %b", c, if1.gnt, want); end
            checks++; if (if1.rsp_valid !== prevWant) begin errors++; $display("[TB] FAIL prio_rsp cycle %0d got %b want %b", c, if1.rsp_valid, prevWant); end
            zeroCnt += int'(if1.gnt[0] === 1'b1);
            prevWant = want;
        end
        checks++; if (zeroCnt != 10) begin errors++; $display("[TB] FAIL prio_count got %0d want 10", zeroCnt); end
        if1.req_valid = '0;
        repeat (2) applyStimulus();
    endtask

    task automatic test_reset_mid_read();
        setReq(1, 1'b1, 1'b0, 15'h0010, '0);
        applyStimulus();
        checks++; if (if0.gnt !== 3'b010) begin errors++; $display("[TB] FAIL mid_gnt got %b want 010", if0.gnt); end
        reset = 1'b1;
        if0.req_valid[1] = 1'b0;
        applyStimulus();
        checks++; if (if0.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL mid_rsp0 got %b want 000", if0.rsp_valid); end
        checks++; if (if0.gnt !== 3'b000) begin errors++; $display("[TB] FAIL mid_gnt_rst got %b want 000", if0.gnt); end
        for (int i = 0; i < N; i++) setReq(i, 1'b1, 1'b0, AW'(48 + i), '0);
        applyStimulus();
        checks++; if (if0.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL mid_rsp1 got %b want 000", if0.rsp_valid); end
        reset = 1'b0;
        applyStimulus();
        checks++; if (if0.gnt !== 3'b001) begin errors++; $display("[TB] FAIL mid_release_gnt got %b want 001", if0.gnt); end
        checks++; if (if0.rsp_valid !== 3'b000) begin errors++; $display("[TB] FAIL mid_rsp2 got %b want 000", if0.rsp_valid); end
        if0.req_valid = '0;
        repeat (2) applyStimulus();
    endtask

    // Scenario sequence.
    initial begin
        reset = 1'b1;
        if0.req_valid = '0; if0.req_we = '0; if0.req_addr = '0; if0.req_wdata = '0;
        if1.req_valid = '0; if1.req_we = '0; if1.req_addr = '0; if1.req_wdata = '0;
        test_reset();
        test_single_read();
        test_write_readback();
        test_round_robin();
        test_random();
        test_prio0();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
